// File: rtl/seg_display_sched.sv
// Round-robin scheduler for the 4-digit multiplexed display: latches a granted 16-bit value, scans MSD first.
// Outputs registered/decoded from state; readies combinational from valids, open only in IDLE or at an eligible frame end.
module seg_display_sched #(
    parameter int DIGIT_CYCLES = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int HOLD_FRAMES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        owner,
    output logic        frame_done
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [FW-1:0] FRM_SAT   = FW'(HOLD_FRAMES - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   disp, disp_nxt;
    logic          owner_nxt;
    logic          last_grant, last_grant_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [FW-1:0] fcnt, fcnt_nxt;
    logic          slot_end;
    logic          window;
    logic          grant0, grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            disp       <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            idx        <= 2'd3;
            cnt        <= '0;
            fcnt       <= '0;
        end else begin
            state      <= state_nxt;
            disp       <= disp_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            fcnt       <= fcnt_nxt;
        end
    end

    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        frame_done = 1'b0;
        an         = 4'b1111;
        digit      = 4'h0;
        if (state == SHOW) begin
            frame_done = slot_end && (idx == 2'd0);
            digit      = disp[{idx, 2'b00} +: 4];
            if (cnt >= CNT_BLANK) begin
                an = ~(4'b0001 << idx);
            end
        end

        window = (state == IDLE) || (frame_done && (fcnt >= FRM_SAT));

        // On contention the requester that did not win last time goes first.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && window) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        req0_ready = grant0;
        req1_ready = grant1;
    end

    always_comb begin
        state_nxt      = state;
        disp_nxt       = disp;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        idx_nxt        = idx;
        cnt_nxt        = cnt;
        fcnt_nxt       = fcnt;

        if (state == SHOW) begin
            cnt_nxt = slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx_nxt = idx - 2'd1;
            end
            if (frame_done && (fcnt != FRM_SAT)) begin
                fcnt_nxt = fcnt + 1'b1;
            end
        end

        if (grant0 || grant1) begin
            state_nxt      = SHOW;
            disp_nxt       = grant1 ? req1_data : req0_data;
            owner_nxt      = grant1;
            last_grant_nxt = grant1;
            idx_nxt        = 2'd3;
            cnt_nxt        = '0;
            fcnt_nxt       = '0;
        end
    end

endmodule

// File: doc/seg_display_sched.md
# seg_display_sched

Display scheduler for the board's multiplexed 4-digit seven-segment display. Two producers share the display through valid/ready handshakes with round-robin arbitration:
- requester 0: FPU result
- requester 1: status/error code

The block latches the granted 16-bit value and time-multiplexes the active-low anodes, most-significant digit first. It inserts blanking between digit slots to prevent ghosting, and holds each message for a minimum number of full frames before accepting a new one. The `digit` output feeds the existing hex-to-segment decoder.

## Interface
- DIGIT_CYCLES, 16: clock cycles per digit slot; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; must be ≥ 1.
- HOLD_FRAMES, 4: minimum complete frames a message is shown before a new grant; must be ≥ 1.

- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has data.
- req0_data  in  16  requester 0 value, four hex nibbles.
- req0_ready  out  1  requester 0 grant; transfer when valid & ready in the same cycle.
- req1_valid  in  1  requester 1 has data.
- req1_data  in  16  requester 1 value.
- req1_ready  out  1  requester 1 grant.
- an  out  4  anodes, active-low; an[3] = leftmost digit.
- digit  out  4  nibble for the current slot.
- owner  out  1  requester whose value is displayed.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- States: IDLE (nothing accepted since reset) and SHOW.
- Reset values:
  - state = IDLE, an = 4'b1111, digit = 0, owner = 0, frame_done = 0.
  - Internal: slot index = 3, slot counter = 0, frame count = 0, last_grant = 1.
  - Both readies = 0 while reset is high.
- Accept window (combinational):
  - open in every IDLE cycle;
  - in SHOW, open only in a cycle where frame_done = 1 and frame count ≥ HOLD_FRAMES−1.
- Arbitration inside an open window:
  - only one valid: that requester gets ready = 1;
  - both valid: the requester ≠ last_grant gets ready = 1, the other gets 0;
  - no valid: both readies are 0.
- Readies depend combinationally on both valids and the window. A requester may not wait for ready before raising valid.
- On a transfer:
  - next cycle: display register = data, owner = granted index, last_grant = granted index;
  - state = SHOW, slot index = 3, slot counter = 0, frame count = 0.
- SHOW scanning:
  - slot counter runs 0..DIGIT_CYCLES−1;
  - counter < BLANK_CYCLES: an = 1111;
  - otherwise: an has only bit [slot index] low;
  - digit = display[4*idx+3 : 4*idx] during the entire slot, including blank cycles.
- Slot progression: at the end of a slot, the index decrements 3→2→1→0, then wraps to 3.
- Frame end: the last cycle of slot 0 is the frame end.
  - frame_done = 1 in that cycle.
  - Frame count increments, saturating at HOLD_FRAMES−1.
- Window open with no valid: scanning continues unchanged; the window reopens at every later frame end.
- Reset mid-operation: the next edge returns to IDLE. A valid/ready coincident with reset high is not a transfer.
- In IDLE: an = 1111, frame_done = 0, digit = 0.

## Timing
- Transfer in cycle T:
  - T+1..T+BLANK_CYCLES: an = 1111, digit = nibble 3;
  - then an = 0111 until T+DIGIT_CYCLES.
- Frame length is 4·DIGIT_CYCLES. The first frame_done is at T+4·DIGIT_CYCLES.
- Earliest next transfer: T + HOLD_FRAMES·4·DIGIT_CYCLES.
- Worst-case wait for a request that is already pending: that time plus zero further frames. A request arriving after the window closes waits one extra frame.
- All outputs except the readies are registered or decoded from registers only. The readies are the sole valid→ready combinational path.
- At most one anode is low in any cycle. The anode output is never low in the cycle directly after a slot change.

## Test plan
Parameters: DIGIT_CYCLES = 8, BLANK_CYCLES = 2, HOLD_FRAMES = 2 (frame = 32 cycles).
- Reset with no valids → an = 1111, digit = 0, owner = 0, both readies 0, frame_done never pulses over 100 cycles.
- req0_valid with 16'h3A7F in IDLE at cycle 0 → req0_ready = 1 in cycle 0. Then:
  - cycles 1–2: an = 1111, digit = 3; cycles 3–8: an = 0111;
  - cycles 9–10: an = 1111, digit = A; cycles 11–16: an = 1011;
  - frame_done in cycles 32 and 64.
- After that transfer, req1_valid held with 16'h00E1 → req1_ready low through cycle 63, high only in cycle 64. From cycle 65: owner = 1, digit = 0.
- Both valids held permanently with different data → grants alternate req0, req1, req0 at cycles 0, 64, 128; owner toggles accordingly.
- Reset pulsed at cycle 20 of a frame while req1_valid = 1 → req1_ready = 0 in that cycle. Next cycle: IDLE, an = 1111. After reset deasserts, req1 is granted immediately.
- No further requests after one transfer → the same 4-slot pattern repeats indefinitely, frame_done every 32 cycles, both readies 0 except in frame_done cycles with a valid present.
